// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and defaults for the timer/period_meter pair
package timer_pkg;

    localparam int PM_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } pm_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - pin synchronizer with rising-edge detector
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer and remember the last synchronized value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures input period in clock cycles, valid/ready result
module period_meter
    import timer_pkg::*;
#(
    parameter int WIDTH       = PM_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sig_i,
    output logic [WIDTH-1:0] period_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overflow_o,
    output logic             busy_o
);

    pm_state_t        state_q;
    pm_state_t        state_d;
    logic             rise;
    logic [WIDTH-1:0] count_q;
    logic             count_sat;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (sig_i),
        .rise_o (rise)
    );

    assign count_sat = &count_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; edges only matter in ARM and MEASURE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ARM;
            ARM:     if (rise) state_d = MEASURE;
            MEASURE: if (rise || count_sat) state_d = HOLD;
            HOLD:    if (ready_i) state_d = start_i ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the current state only, so valid never follows ready combinationally
    always_comb begin
        valid_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            ARM, MEASURE: busy_o  = 1'b1;
            HOLD:         valid_o = 1'b1;
            default:      ;
        endcase
    end

    // Saturating counter and result registers; the result is only written when leaving MEASURE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            period_o   <= '0;
            overflow_o <= 1'b0;
        end else begin
            case (state_q)
                ARM: begin
                    if (rise) count_q <= WIDTH'(1);
                end
                MEASURE: begin
                    if (rise) begin
                        period_o   <= count_q;
                        overflow_o <= 1'b0;
                    end else if (count_sat) begin
                        period_o   <= '1;
                        overflow_o <= 1'b1;
                    end else begin
                        count_q <= count_q + WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
